// File: rtl/ysyx_22041412_mdu_ctrl_pkg.sv
// Shared FSM state encoding, RV M func3 codes and small decode helpers for the MDU controller.
package ysyx_22041412_mdu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MUL_GO = 3'd1,
    S_DIV_GO = 3'd2,
    S_WAIT   = 3'd3,
    S_DRAIN  = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  function automatic logic [1:0] mul_mode(input logic [2:0] f3);
    logic [1:0] m;
    m = 2'b00;
    case (f3)
      F3_MUL, F3_MULH: m = 2'b11;
      F3_MULHSU:       m = 2'b10;
      F3_MULHU:        m = 2'b00;
      default:         m = 2'b00;
    endcase
    return m;
  endfunction

  function automatic logic is_div(input logic [2:0] f3);
    return f3 inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU};
  endfunction

  function automatic logic div_is_signed(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic div_is_rem(input logic [2:0] f3);
    return (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

endpackage

// File: rtl/ysyx_22041412_div_special.sv
// Detects divide-by-zero and signed overflow on the low W bits and returns the architectural result.
// Purely combinational; value is unformatted (caller sign-extends W ops).
module ysyx_22041412_div_special #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_word,
  input  logic            i_signed,
  input  logic            i_rem,
  output logic            o_hit,
  output logic [XLEN-1:0] o_value
);

  logic            w_b_zero;
  logic            w_ovf;
  logic [XLEN-1:0] w_min;

  always_comb begin
    w_b_zero = i_word ? (i_b[31:0] == 32'd0) : (i_b == '0);
    w_ovf    = i_signed & (i_word
               ? ((i_a[31:0] == 32'h8000_0000) && (i_b[31:0] == 32'hFFFF_FFFF))
               : ((i_a == {1'b1, {(XLEN-1){1'b0}}}) && (i_b == {XLEN{1'b1}})));
    w_min    = i_word ? {{(XLEN-32){1'b0}}, 32'h8000_0000} : {1'b1, {(XLEN-1){1'b0}}};
    o_hit    = w_b_zero | w_ovf;
    o_value  = '0;
    if (w_b_zero)  o_value = i_rem ? i_a : {XLEN{1'b1}};
    else if (w_ovf) o_value = i_rem ? '0 : w_min;
  end

endmodule

// File: rtl/ysyx_22041412_mdu_ctrl.sv
// Sequences the multi-cycle multiplier/divider for M-extension ops and holds the formatted result for WB.
// Special divides resolve in one cycle without touching the divider; flush drains a launched unit.
module ysyx_22041412_mdu_ctrl
  import ysyx_22041412_mdu_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [XLEN-1:0] req_src1_i,
  input  logic [XLEN-1:0] req_src2_i,
  input  logic [2:0]      req_func3_i,
  input  logic            req_word_i,
  output logic            mul_valid_o,
  output logic [1:0]      mul_signed_o,
  output logic            mul_hi_o,
  input  logic            mul_done_i,
  input  logic [XLEN-1:0] mul_res_i,
  output logic            div_valid_o,
  output logic            div_signed_o,
  output logic            div_rem_o,
  input  logic            div_done_i,
  input  logic [XLEN-1:0] div_res_i,
  output logic [XLEN-1:0] unit_a_o,
  output logic [XLEN-1:0] unit_b_o,
  output logic            unit_word_o,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] resp_data_o,
  output logic            busy_o
);

  state_t          r_state;
  logic            r_is_div;
  logic            w_accept;
  logic            w_done;
  logic [XLEN-1:0] w_res;
  logic            w_sp_hit;
  logic [XLEN-1:0] w_sp_value;

  function automatic logic [XLEN-1:0] fmt(input logic [XLEN-1:0] r, input logic w);
    return w ? {{(XLEN-32){r[31]}}, r[31:0]} : r;
  endfunction

  // Holding ready low during reset keeps every output at zero while rst is asserted.
  assign req_ready_o = (r_state == S_IDLE) & ~flush_i & rst;
  assign busy_o      = (r_state != S_IDLE);
  assign w_accept    = req_valid_i & req_ready_o;
  assign w_done      = r_is_div ? div_done_i : mul_done_i;
  assign w_res       = r_is_div ? div_res_i : mul_res_i;

  ysyx_22041412_div_special #(.XLEN(XLEN)) u_div_special (
    .i_a      (req_src1_i),
    .i_b      (req_src2_i),
    .i_word   (req_word_i),
    .i_signed (div_is_signed(req_func3_i)),
    .i_rem    (div_is_rem(req_func3_i)),
    .o_hit    (w_sp_hit),
    .o_value  (w_sp_value)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_is_div     <= 1'b0;
      mul_valid_o  <= 1'b0;
      mul_signed_o <= 2'b00;
      mul_hi_o     <= 1'b0;
      div_valid_o  <= 1'b0;
      div_signed_o <= 1'b0;
      div_rem_o    <= 1'b0;
      unit_a_o     <= '0;
      unit_b_o     <= '0;
      unit_word_o  <= 1'b0;
      resp_valid_o <= 1'b0;
      resp_data_o  <= '0;
    end else begin
      mul_valid_o <= 1'b0;
      div_valid_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            unit_a_o    <= req_src1_i;
            unit_b_o    <= req_src2_i;
            unit_word_o <= req_word_i;
            if (!is_div(req_func3_i)) begin
              r_is_div     <= 1'b0;
              mul_signed_o <= mul_mode(req_func3_i);
              mul_hi_o     <= (req_func3_i != F3_MUL);
              mul_valid_o  <= 1'b1;
              r_state      <= S_MUL_GO;
            end else begin
              r_is_div     <= 1'b1;
              div_signed_o <= div_is_signed(req_func3_i);
              div_rem_o    <= div_is_rem(req_func3_i);
              if (w_sp_hit) begin
                resp_data_o  <= fmt(w_sp_value, req_word_i);
                resp_valid_o <= 1'b1;
                r_state      <= S_RESP;
              end else begin
                div_valid_o <= 1'b1;
                r_state     <= S_DIV_GO;
              end
            end
          end
        end
        // The launch pulse is already on the wire here, so a flush can only drain.
        S_MUL_GO, S_DIV_GO: r_state <= flush_i ? S_DRAIN : S_WAIT;
        S_WAIT: begin
          if (w_done) begin
            if (flush_i) begin
              r_state <= S_IDLE;
            end else begin
              resp_data_o  <= fmt(w_res, unit_word_o);
              resp_valid_o <= 1'b1;
              r_state      <= S_RESP;
            end
          end else if (flush_i) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: if (w_done) r_state <= S_IDLE;
        S_RESP: begin
          if (flush_i || resp_ready_i) begin
            resp_valid_o <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041412_mdu_ctrl.sv
// Scoreboard bench for the MDU controller with behavioural mul/div unit models.
module tb_ysyx_22041412_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [63:0] req_src1_i = '0;
  logic [63:0] req_src2_i = '0;
  logic [2:0]  req_func3_i = '0;
  logic        req_word_i = 1'b0;
  logic        mul_valid_o;
  logic [1:0]  mul_signed_o;
  logic        mul_hi_o;
  logic        mul_done_i = 1'b0;
  logic [63:0] mul_res_i = '0;
  logic        div_valid_o;
  logic        div_signed_o;
  logic        div_rem_o;
  logic        div_done_i = 1'b0;
  logic [63:0] div_res_i = '0;
  logic [63:0] unit_a_o;
  logic [63:0] unit_b_o;
  logic        unit_word_o;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b1;
  logic [63:0] resp_data_o;
  logic        busy_o;

  ysyx_22041412_mdu_ctrl #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_src1_i(req_src1_i), .req_src2_i(req_src2_i),
    .req_func3_i(req_func3_i), .req_word_i(req_word_i),
    .mul_valid_o(mul_valid_o), .mul_signed_o(mul_signed_o), .mul_hi_o(mul_hi_o),
    .mul_done_i(mul_done_i), .mul_res_i(mul_res_i),
    .div_valid_o(div_valid_o), .div_signed_o(div_signed_o), .div_rem_o(div_rem_o),
    .div_done_i(div_done_i), .div_res_i(div_res_i),
    .unit_a_o(unit_a_o), .unit_b_o(unit_b_o), .unit_word_o(unit_word_o),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_data_o(resp_data_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int resp_cyc = 0;
  int mul_cnt = 0, div_cnt = 0;
  int mul_lat = 2, div_lat = 2;
  int mul_pulses = 0, div_pulses = 0;
  int div_done_cyc = 0;
  logic [63:0] unit_val = '0;
  logic [1:0]  last_mul_signed = '0;
  logic        last_mul_hi = 1'b0;
  logic        last_div_signed = 1'b0;
  logic        last_div_rem = 1'b0;
  logic [63:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: wait budget expired", nm);
  endtask

  // Unit models: a launch seen now produces a one-cycle done 'lat' cycles later.
  always @(posedge clk) begin
    #1;
    mul_done_i = 1'b0;
    if (mul_cnt > 0) begin
      mul_cnt--;
      if (mul_cnt == 0) begin mul_done_i = 1'b1; mul_res_i = unit_val; end
    end
    if (mul_valid_o) begin
      mul_cnt = mul_lat; mul_pulses++;
      last_mul_signed = mul_signed_o; last_mul_hi = mul_hi_o;
    end
    div_done_i = 1'b0;
    if (div_cnt > 0) begin
      div_cnt--;
      if (div_cnt == 0) begin div_done_i = 1'b1; div_res_i = unit_val; div_done_cyc = cyc; end
    end
    if (div_valid_o) begin
      div_cnt = div_lat; div_pulses++;
      last_div_signed = div_signed_o; last_div_rem = div_rem_o;
    end
  end

  // Monitor: every accepted response is checked against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && resp_valid_o && resp_ready_i) begin
      resp_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", resp_data_o, 64'hx);
      end else begin
        chk("resp_data", resp_data_o, exp_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [63:0] s1, input logic [63:0] s2, input logic [2:0] f3,
                       input logic w, input logic [63:0] ures, input int lat,
                       input logic push, input logic [63:0] exp);
    int n = 0;
    @(negedge clk);
    while (!req_ready_o && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout("req_ready");
    req_src1_i = s1; req_src2_i = s2; req_func3_i = f3; req_word_i = w;
    unit_val = ures; mul_lat = lat; div_lat = lat;
    if (push) exp_q.push_back(exp);
    acc_cyc = cyc;
    req_valid_i = 1'b1;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy_o && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) timeout("wait_idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] hold;
    int n;
    logic saw;
    int ready_cyc;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_resp_data", resp_data_o, 0);
    chk("rst_unit_a", unit_a_o, 0);
    chk("rst_mul_valid", mul_valid_o, 0);
    rst = 1'b1;

    // MUL 3 * -2
    issue(64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 3'b000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFA, 5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA);
    wait_idle();
    chk("mul_latency", resp_cyc - acc_cyc, 7);
    chk("mul_pulses", mul_pulses, 1);
    chk("mul_signed", last_mul_signed, 2'b11);
    chk("mul_hi", last_mul_hi, 0);
    chk("unit_a", unit_a_o, 64'd3);

    // MULHU all-ones * 2
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 3'b011, 1'b0, 64'd1, 3, 1'b1, 64'd1);
    wait_idle();
    chk("mulhu_signed", last_mul_signed, 2'b00);
    chk("mulhu_hi", last_mul_hi, 1);
    chk("mulhu_pulses", mul_pulses, 2);

    // Special divides never launch the divider
    issue(64'd7, 64'd0, 3'b100, 1'b1, 64'h0, 4, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_idle();
    chk("divw0_latency", resp_cyc - acc_cyc, 1);
    issue(64'd7, 64'd0, 3'b111, 1'b1, 64'h0, 4, 1'b1, 64'd7);
    wait_idle();
    issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'b100, 1'b0, 64'h0, 4, 1'b1, 64'h8000_0000_0000_0000);
    wait_idle();
    issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'b110, 1'b0, 64'h0, 4, 1'b1, 64'h0);
    wait_idle();
    issue(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 3'b100, 1'b1, 64'h0, 4, 1'b1, 64'hFFFF_FFFF_8000_0000);
    wait_idle();
    chk("special_no_div_launch", div_pulses, 0);

    // DIVW -7/2 through the divider; raw low-word result gets sign-extended
    issue(64'h0000_0000_FFFF_FFF9, 64'd2, 3'b100, 1'b1, 64'h0000_0000_FFFF_FFFD, 4, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
    wait_idle();
    chk("divw_pulses", div_pulses, 1);
    chk("divw_signed", last_div_signed, 1);
    chk("divw_rem", last_div_rem, 0);
    chk("divw_latency", resp_cyc - acc_cyc, 6);

    // Flush while waiting on the divider
    issue(64'd100, 64'd7, 3'b110, 1'b0, 64'd2, 8, 1'b0, 64'h0);
    repeat (2) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    saw = 1'b0; n = 0; ready_cyc = 0;
    while (!req_ready_o && n < 40) begin
      if (resp_valid_o) saw = 1'b1;
      @(negedge clk); n++;
    end
    if (n >= 40) timeout("drain_ready");
    ready_cyc = cyc;
    chk("flush_no_resp", saw, 0);
    chk("flush_div_rem", last_div_rem, 1);
    chk("drain_ready_cycle", ready_cyc, div_done_cyc + 1);

    issue(64'd6, 64'd7, 3'b000, 1'b0, 64'd42, 3, 1'b1, 64'd42);
    wait_idle();

    // Backpressure
    resp_ready_i = 1'b0;
    issue(64'd5, 64'd5, 3'b000, 1'b0, 64'd25, 2, 1'b1, 64'd25);
    n = 0;
    while (!resp_valid_o && n < 30) begin @(negedge clk); n++; end
    if (n >= 30) timeout("bp_resp_valid");
    hold = resp_data_o;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_data_stable", resp_data_o, hold);
      chk("bp_req_ready", req_ready_o, 0);
    end
    @(posedge clk);
    #1 resp_ready_i = 1'b1;
    wait_idle();

    // Reset in the middle of WAIT
    issue(64'd9, 64'd9, 3'b001, 1'b0, 64'd0, 10, 1'b0, 64'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_busy", busy_o, 0);
    chk("midrst_unit_a", unit_a_o, 0);
    chk("midrst_mul_signed", mul_signed_o, 0);
    chk("midrst_req_ready", req_ready_o, 0);
    @(negedge clk);
    rst = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (resp_valid_o || busy_o) saw = 1'b1;
    end
    chk("stale_done_ignored", saw, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
